speaker_tone_scheduler: RTL and testbench
=========================================

# speaker_tone_scheduler

Shares one speaker output among N_REQ requesters (alarm, UI beep, status chime, test) by round-robin arbitration. Each requester's tone is a half-period in clk cycles plus a duration in millisecond ticks. The block owns the square-wave generator, times each tone, and inserts a silence gap between tones. It sits between the control logic and the speaker DAC pin and replaces free-running per-speaker counters.

## Interface
- N_REQ, 4: number of requesters (2..8).
- HP_W, 16: half-period width in clk cycles.
- DUR_W, 12: duration width in ticks.
- TICK_CYCLES, 32000: clk cycles per tick (1 ms at 32 MHz).
- GAP_TICKS, 1: silent ticks between tones (0 allowed).

Ports:
- clk  in  1  clock, 32 MHz nominal.
- resetn  in  1  reset, synchronous, active-low.
- req  in  N_REQ  per-requester request level; held until gnt.
- half_period  in  N_REQ*HP_W  packed; slice i belongs to req[i]; 0 = rest (silence).
- duration  in  N_REQ*DUR_W  packed; slice i belongs to req[i]; tone length in ticks.
- abort  in  1  ends the current tone early.
- gnt  out  N_REQ  one-cycle one-hot pulse: request accepted.
- done  out  N_REQ  one-cycle one-hot pulse: granted tone finished.
- busy  out  1  high in PLAY or GAP.
- active_id  out  3  index of the current owner; valid while busy.
- spk_pin  out  1  square wave to DAC.

## Operation
- FSM states: IDLE, PLAY, GAP.
- IDLE, any req high: select the first set bit at or after rr_ptr (wrapping). On the same edge:
  - register gnt[sel];
  - latch half_period and duration slices into hp_q and dur_q;
  - set active_id to sel and rr_ptr to sel+1 mod N_REQ;
  - clear the tick and tone counters;
  - go to PLAY.
- Requester rules:
  - A requester must drop req the cycle after its gnt. If it does not, the request counts as a new request.
  - Dropping req before gnt withdraws the request.
- PLAY:
  - Tone counter counts 0..hp_q-1. At hp_q-1 it wraps and toggles spk_pin, giving a period of 2*hp_q cycles.
  - hp_q==0: spk_pin held 0.
  - hp_q==1: spk_pin toggles every cycle.
- Tick counter counts 0..TICK_CYCLES-1. Each wrap decrements dur_q. When dur_q reaches 0:
  - pulse done[active_id];
  - force spk_pin to 0;
  - go to GAP, or to IDLE if GAP_TICKS==0.
- duration==0: PLAY lasts one cycle, done pulses, spk_pin stays 0.
- abort in PLAY: same exit as normal completion on the next edge. abort is ignored in IDLE and GAP.
- GAP: spk_pin 0 for GAP_TICKS*TICK_CYCLES cycles, then IDLE. Requests arriving during PLAY or GAP wait.
- Reset mid-operation: state goes to IDLE; no done pulse is issued; rr_ptr returns to 0.

## Timing
- Reset values: gnt=0, done=0, busy=0, active_id=0, spk_pin=0, rr_ptr=0, state IDLE.
- Grant latency: req is sampled high at edge E while in IDLE. gnt is high in the cycle after E; busy is high from E onward.
- First spk_pin rise comes hp_q cycles after entering PLAY.
- PLAY length is exactly dur_q*TICK_CYCLES cycles (1 cycle if dur_q==0).
  - done is high in the first cycle after PLAY.
  - spk_pin is low in that same cycle.
- An abort sampled at edge A: spk_pin is 0 and done is high in the cycle after A.
- Back-to-back tones: the next gnt comes at the earliest GAP_TICKS*TICK_CYCLES+1 cycles after done.
- Simultaneous requests: exactly one gnt per arbitration; the others are served in round-robin order.

## Structure
- Package speaker_pkg holds:
  - the state enum;
  - CLK_HZ = 32_000_000;
  - the default TICK_CYCLES;
  - NOTE_HP, the half-period constants for the 17 speaker notes (CLK_HZ/(2*f), e.g. 400 Hz → 40000, 800 Hz → 20000).
- Sub-module speaker_tone_gen: tone counter plus toggle flop, with inputs clk, resetn, en, hp and output wave. The scheduler gates it with en=(state==PLAY).

## Test plan
All scenarios use TICK_CYCLES=10 and GAP_TICKS=1.
- req[0], hp=3, dur=2 → gnt[0] pulse; spk_pin toggles every 3 cycles for 20 cycles; done[0] pulse; spk_pin 0.
- req[1] and req[2] raised in the same cycle with rr_ptr=0 → gnt[1] first. After done[1] and 10 gap cycles, gnt[2].
- req[3:0] held continuously, each dropped for one cycle after its gnt → grant order 0,1,2,3,0.
- hp=0, dur=3 → 30 cycles busy with spk_pin constantly 0, then done. Separately, dur=0 → done the cycle after PLAY, spk_pin never high.
- abort 7 cycles into a hp=2, dur=5 tone → spk_pin 0 and done pulse the next cycle, then GAP, then IDLE.
- resetn low for 1 cycle mid-PLAY → all outputs 0, no done pulse, a new req granted afterwards starting from rr_ptr 0.

Source files
------------

// File: rtl/speaker_tone_scheduler_pkg.sv
// speaker_pkg: shared types and constants for the speaker tone scheduler.
//   state_t         scheduler FSM state encoding
//   CLK_HZ          nominal system clock
//   TICK_CYCLES_DEF clk cycles per 1 ms tick at CLK_HZ
//   NOTE_HP         half-period (clk cycles) for 17 chromatic notes from 400 Hz
package speaker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ          = 32_000_000;
  localparam int unsigned TICK_CYCLES_DEF = CLK_HZ / 1000;
  localparam int unsigned NUM_NOTES       = 17;

  // CLK_HZ / (2 * f), f = 400 Hz * 2^(k/12), k = 0..16, rounded to nearest.
  localparam logic [15:0] NOTE_HP [NUM_NOTES] = '{
    16'd40000, 16'd37755, 16'd35636, 16'd33636, 16'd31748, 16'd29966,
    16'd28284, 16'd26697, 16'd25198, 16'd23784, 16'd22449, 16'd21189,
    16'd20000, 16'd18877, 16'd17818, 16'd16818, 16'd15874
  };

endpackage

// File: rtl/speaker_tone_scheduler_if.sv
// speaker_tone_scheduler_if: request/grant and speaker output bundle.
//   req, half_period, duration, abort   control side -> scheduler
//   gnt, done, busy, active_id, spk_pin scheduler -> control side / DAC
// half_period and duration are packed per requester; slice i belongs to req[i].
interface speaker_tone_scheduler_if
  import speaker_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int HP_W  = 16,
  parameter int DUR_W = 12
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*HP_W-1:0]  half_period;
  logic [N_REQ*DUR_W-1:0] duration;
  logic                   abort;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [2:0]             active_id;
  logic                   spk_pin;

  modport master (
    output req, half_period, duration, abort,
    input  gnt, done, busy, active_id, spk_pin
  );

  modport slave (
    input  req, half_period, duration, abort,
    output gnt, done, busy, active_id, spk_pin
  );

endinterface

// File: rtl/speaker_tone_scheduler_tone_gen.sv
// speaker_tone_gen: square-wave generator.
//   clk, resetn  clock and synchronous active-low reset
//   en           run the generator; low clears counter and forces wave to 0
//   hp           half-period in clk cycles; 0 means silence
//   wave         registered square wave, period 2*hp cycles
module speaker_tone_gen
  import speaker_pkg::*;
#(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic [HP_W-1:0] hp,
  output logic            wave
);

  logic [HP_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!en || hp == '0) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt == hp - HP_W'(1)) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/speaker_tone_scheduler.sv
// speaker_tone_scheduler: round-robin owner of a single speaker output.
//   clk, resetn  clock and synchronous active-low reset
//   bus (slave)  req/half_period/duration/abort in; gnt/done/busy/active_id/spk_pin out
// A granted requester plays a square wave of its half-period for its duration in
// ticks, followed by GAP_TICKS silent ticks before the next arbitration.
//
//   state | meaning
//   IDLE  | waiting for any req; arbitrates from rr_ptr on the next edge
//   PLAY  | tone running; tick timer counts down, dur_q counts ticks left
//   GAP   | enforced silence between tones
module speaker_tone_scheduler
  import speaker_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HP_W        = 16,
  parameter int DUR_W       = 12,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int GAP_TICKS   = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  speaker_tone_scheduler_if.slave   bus
);

  localparam int ID_W    = 3;
  localparam int TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GAP_CYC = GAP_TICKS * TICK_CYCLES;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   sel;
  logic              found;
  logic [HP_W-1:0]   sel_hp;
  logic [DUR_W-1:0]  sel_dur;
  logic [HP_W-1:0]   hp_q;
  logic [DUR_W-1:0]  dur_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic              busy_q;
  logic [ID_W-1:0]   active_id_q;
  logic              tick_tc;
  logic              play_end;
  logic              play_en;
  logic              wave;

  // First pending request at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && ((bus.req & (N_REQ'(1) << idx)) != '0)) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_hp  = '0;
    sel_dur = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(sel) == i) begin
        sel_hp  = bus.half_period[i*HP_W +: HP_W];
        sel_dur = bus.duration[i*DUR_W +: DUR_W];
      end
    end
  end

  assign tick_tc  = (tick_cnt == '0);
  // Exit on the edge that ends the last PLAY cycle; zero duration plays one cycle.
  assign play_end = (state == ST_PLAY) &&
                    (bus.abort || dur_q == '0 || (tick_tc && dur_q == DUR_W'(1)));
  // Dropping en on the exit edge makes the generator clear spk_pin in the done cycle.
  assign play_en  = (state == ST_PLAY) && !play_end;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      hp_q        <= '0;
      dur_q       <= '0;
      tick_cnt    <= '0;
      gap_cnt     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            state       <= ST_PLAY;
            gnt_q       <= N_REQ'(1) << sel;
            hp_q        <= sel_hp;
            dur_q       <= sel_dur;
            active_id_q <= sel;
            rr_ptr      <= (int'(sel) == N_REQ - 1) ? '0 : sel + ID_W'(1);
            tick_cnt    <= TICK_W'(TICK_CYCLES - 1);
            busy_q      <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (play_end) begin
            done_q <= N_REQ'(1) << active_id_q;
            if (GAP_TICKS == 0) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_W'(GAP_CYC - 1);
            end
          end else if (tick_tc) begin
            tick_cnt <= TICK_W'(TICK_CYCLES - 1);
            dur_q    <= dur_q - DUR_W'(1);
          end else begin
            tick_cnt <= tick_cnt - TICK_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  speaker_tone_gen #(
    .HP_W (HP_W)
  ) u_tone_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (play_en),
    .hp     (hp_q),
    .wave   (wave)
  );

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_id_q;
  assign bus.spk_pin   = wave;

endmodule

// File: tb/tb_speaker_tone_scheduler.sv
module tb_speaker_tone_scheduler;

  localparam int N   = 4;
  localparam int HPW = 16;
  localparam int DW  = 12;
  localparam int T   = 10;
  localparam int G   = 1;

  localparam int S_GNT  = 0;
  localparam int S_DONE = 1;
  localparam int S_BUSY = 2;
  localparam int S_ID   = 3;
  localparam int S_SPK  = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  speaker_tone_scheduler_if #(.N_REQ(N), .HP_W(HPW), .DUR_W(DW)) bus ();

  speaker_tone_scheduler #(
    .N_REQ(N), .HP_W(HPW), .DUR_W(DW), .TICK_CYCLES(T), .GAP_TICKS(G)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t ev_q[$];   // expected gnt/done pulses, ordered by cycle
  exp_t smp_q[$];  // expected output levels at given cycles
  exp_t mon_e;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(input int c, input int s, input int v);
    exp_t e;
    int i;
    e.cyc = c; e.sig = s; e.val = v;
    i = ev_q.size();
    while (i > 0 && ev_q[i-1].cyc > c) i--;
    ev_q.insert(i, e);
  endfunction

  function automatic void push_smp(input int c, input int s, input int v);
    exp_t e;
    int i;
    e.cyc = c; e.sig = s; e.val = v;
    i = smp_q.size();
    while (i > 0 && smp_q[i-1].cyc > c) i--;
    smp_q.insert(i, e);
  endfunction

  function automatic string sname(input int s);
    case (s)
      S_GNT:   return "gnt";
      S_DONE:  return "done";
      S_BUSY:  return "busy";
      S_ID:    return "active_id";
      default: return "spk_pin";
    endcase
  endfunction

  function automatic int dut_val(input int s);
    case (s)
      S_GNT:   return int'(bus.gnt);
      S_DONE:  return int'(bus.done);
      S_BUSY:  return int'(bus.busy);
      S_ID:    return int'(bus.active_id);
      default: return int'(bus.spk_pin);
    endcase
  endfunction

  function automatic void check(input string what, input int act, input int exp, input int at_c);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", what, at_c, act, exp);
    end
  endfunction

  function automatic void observe(input int s, input int v);
    if (ev_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected %s pulse @cycle %0d: got %0d, expected none", sname(s), cyc, v);
    end else begin
      mon_e = ev_q.pop_front();
      check("event kind", s, mon_e.sig, cyc);
      check({sname(s), " vector"}, v, mon_e.val, cyc);
      check({sname(s), " cycle"}, cyc, mon_e.cyc, cyc);
    end
  endfunction

  // Monitor: pulses pop the event queue; level samples pop when their cycle comes.
  always @(negedge clk) begin
    if (bus.gnt != '0)  observe(S_GNT, int'(bus.gnt));
    if (bus.done != '0) observe(S_DONE, int'(bus.done));
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      mon_e = ev_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing %s pulse @cycle %0d: got none, expected %0d", sname(mon_e.sig), mon_e.cyc, mon_e.val);
    end
    while (smp_q.size() > 0 && smp_q[0].cyc <= cyc) begin
      mon_e = smp_q.pop_front();
      check(sname(mon_e.sig), dut_val(mon_e.sig), mon_e.val, mon_e.cyc);
    end
  end

  task automatic at(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic set_tone(input int id, input int hp, input int dur);
    bus.half_period[id*HPW +: HPW] = HPW'(hp);
    bus.duration[id*DW +: DW]      = DW'(dur);
  endtask

  // Single requester tone from IDLE, optional abort driven during PLAY cycle abort_k.
  task automatic play_one(input int id, input int hp, input int dur, input int abort_k);
    int c, plen, v;
    c    = cyc;
    plen = (dur == 0) ? 1 : dur * T;
    if (abort_k > 0 && abort_k < plen) plen = abort_k;
    push_ev(c + 1, S_GNT, 1 << id);
    push_ev(c + 1 + plen, S_DONE, 1 << id);
    push_smp(c + 1, S_ID, id);
    for (int k = 1; k <= plen + G*T + 1; k++) begin
      v = (k <= plen && hp != 0) ? ((k - 1) / hp) % 2 : 0;
      push_smp(c + k, S_SPK, v);
    end
    push_smp(c + 1, S_BUSY, 1);
    push_smp(c + plen, S_BUSY, 1);
    push_smp(c + plen + G*T, S_BUSY, 1);
    push_smp(c + plen + G*T + 1, S_BUSY, 0);
    set_tone(id, hp, dur);
    bus.req[id] = 1'b1;
    at(c + 1);
    bus.req[id] = 1'b0;
    if (abort_k > 0) begin
      at(c + abort_k);
      bus.abort = 1'b1;
      at(c + abort_k + 1);
      bus.abort = 1'b0;
    end
    at(c + 1 + plen + G*T);
  endtask

  // req[1] and req[2] together with rr_ptr at 0.
  task automatic pair_test();
    int c;
    c = cyc;
    push_ev(c + 1,  S_GNT,  4'b0010);
    push_ev(c + 11, S_DONE, 4'b0010);
    push_ev(c + 22, S_GNT,  4'b0100);
    push_ev(c + 32, S_DONE, 4'b0100);
    push_smp(c + 1,  S_ID, 1);
    push_smp(c + 11, S_SPK, 0);
    push_smp(c + 21, S_BUSY, 0);
    push_smp(c + 22, S_BUSY, 1);
    push_smp(c + 22, S_ID, 2);
    set_tone(1, 4, 1);
    set_tone(2, 4, 1);
    bus.req = 4'b0110;
    at(c + 1);
    bus.req[1] = 1'b0;
    at(c + 22);
    bus.req[2] = 1'b0;
    at(c + 42);
  endtask

  // All four held; each drops req for one cycle after its grant.
  task automatic hold_test();
    int c, per;
    c   = cyc;
    per = 2*T + 1;
    for (int n = 0; n < 5; n++) begin
      push_ev(c + 1 + per*n, S_GNT,  1 << (n % 4));
      push_ev(c + 11 + per*n, S_DONE, 1 << (n % 4));
      push_smp(c + 1 + per*n, S_ID, n % 4);
    end
    for (int i = 0; i < N; i++) set_tone(i, 2, 1);
    bus.req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      at(c + 1 + per*n);
      bus.req[n % 4] = 1'b0;
      if (n == 4) begin
        bus.req = '0;
      end else begin
        at(c + 2 + per*n);
        bus.req[n % 4] = 1'b1;
      end
    end
    at(c + 105);
  endtask

  // One-cycle reset in the middle of a tone, then arbitration from rr_ptr 0.
  task automatic reset_test();
    int c;
    c = cyc;
    push_ev(c + 1, S_GNT, 4'b0100);
    push_smp(c + 4, S_SPK, 1);
    push_smp(c + 5, S_BUSY, 1);
    push_smp(c + 6, S_GNT, 0);
    push_smp(c + 6, S_DONE, 0);
    push_smp(c + 6, S_BUSY, 0);
    push_smp(c + 6, S_ID, 0);
    push_smp(c + 6, S_SPK, 0);
    push_ev(c + 8,  S_GNT,  4'b0010);
    push_ev(c + 18, S_DONE, 4'b0010);
    push_ev(c + 29, S_GNT,  4'b1000);
    push_ev(c + 39, S_DONE, 4'b1000);
    push_smp(c + 8, S_ID, 1);
    push_smp(c + 29, S_ID, 3);
    set_tone(2, 3, 4);
    bus.req[2] = 1'b1;
    at(c + 1);
    bus.req[2] = 1'b0;
    at(c + 5);
    resetn = 1'b0;
    at(c + 6);
    resetn = 1'b1;
    at(c + 7);
    set_tone(1, 2, 1);
    set_tone(3, 2, 1);
    bus.req = 4'b1010;
    at(c + 8);
    bus.req[1] = 1'b0;
    at(c + 29);
    bus.req[3] = 1'b0;
    at(c + 49);
  endtask

  initial begin
    resetn          = 1'b0;
    bus.req         = '0;
    bus.half_period = '0;
    bus.duration    = '0;
    bus.abort       = 1'b0;
    @(negedge clk);
    push_smp(2, S_GNT, 0);
    push_smp(2, S_DONE, 0);
    push_smp(2, S_BUSY, 0);
    push_smp(2, S_ID, 0);
    push_smp(2, S_SPK, 0);
    at(2);
    resetn = 1'b1;
    at(4);
    pair_test();              // rr_ptr 0 -> gnt1, gnt2
    play_one(3, 5, 1, 0);     // rr_ptr back to 0
    hold_test();              // order 0,1,2,3,0
    play_one(0, 3, 2, 0);     // basic tone, wraps from rr_ptr 1
    play_one(1, 0, 3, 0);     // rest: silent for 30 cycles
    play_one(2, 1, 0, 0);     // zero duration, toggle suppressed
    play_one(3, 2, 5, 7);     // abort 7 cycles in
    reset_test();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
